// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// presses and releases in scan ticks, and emits one key-code strobe per press.
module keypad_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] Dout,
   output logic       Ce,
   output logic       Held
);

   localparam int              PRE_W   = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
   localparam logic [3:0]      DEB_TGT = 4'(DEBOUNCE);

   localparam logic [1:0] S_SCAN         = 2'd0;
   localparam logic [1:0] S_DEBOUNCE     = 2'd1;
   localparam logic [1:0] S_PRESSED      = 2'd2;
   localparam logic [1:0] S_WAIT_RELEASE = 2'd3;

   logic [3:0]       r_rowMeta;
   logic [3:0]       r_rowSync;
   logic [PRE_W-1:0] r_preCnt;
   logic [1:0]       r_state;
   logic [1:0]       r_colIdx;
   logic [1:0]       r_candRow;
   logic [1:0]       r_candCol;
   logic [3:0]       r_debCnt;
   logic [3:0]       r_relCnt;
   logic [3:0]       r_dout;
   logic             r_ce;
   logic             r_held;

   logic             w_tick;
   logic             w_rowIdle;
   logic [1:0]       w_lowRow;
   logic             w_candLow;
   logic [3:0]       w_debInc;
   logic [3:0]       w_relInc;

   // ROW is asynchronous; idle (pulled-up) value is all ones.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rowMeta <= 4'b1111;
         r_rowSync <= 4'b1111;
      end else begin
         r_rowMeta <= ROW;
         r_rowSync <= r_rowMeta;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || w_tick) begin
         r_preCnt <= '0;
      end else begin
         r_preCnt <= r_preCnt + PRE_W'(1);
      end
   end

   assign w_tick    = (r_preCnt == PRE_MAX);
   assign w_rowIdle = (r_rowSync == 4'b1111);
   assign w_candLow = ~r_rowSync[r_candRow];
   assign w_debInc  = r_debCnt + 4'd1;
   assign w_relInc  = r_relCnt + 4'd1;

   // Lowest-index active row wins when several rows are low together.
   always_comb begin
      w_lowRow = 2'd3;
      if (!r_rowSync[0]) begin
         w_lowRow = 2'd0;
      end else if (!r_rowSync[1]) begin
         w_lowRow = 2'd1;
      end else if (!r_rowSync[2]) begin
         w_lowRow = 2'd2;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_SCAN;
         r_colIdx  <= 2'd0;
         r_candRow <= 2'd0;
         r_candCol <= 2'd0;
         r_debCnt  <= 4'd0;
         r_relCnt  <= 4'd0;
         r_dout    <= 4'h0;
         r_ce      <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_ce <= 1'b0;
         case (r_state)
            S_SCAN: begin
               if (w_tick) begin
                  if (w_rowIdle) begin
                     r_colIdx <= r_colIdx + 2'd1;
                  end else begin
                     r_candRow <= w_lowRow;
                     r_candCol <= r_colIdx;
                     r_debCnt  <= 4'd1;
                     // A single-sample debounce skips straight to the strobe.
                     if (DEBOUNCE == 1) begin
                        r_state <= S_PRESSED;
                        r_ce    <= 1'b1;
                        r_dout  <= {w_lowRow, r_colIdx};
                        r_held  <= 1'b1;
                     end else begin
                        r_state <= S_DEBOUNCE;
                     end
                  end
               end
            end

            S_DEBOUNCE: begin
               if (w_tick) begin
                  if (w_candLow) begin
                     r_debCnt <= w_debInc;
                     if (w_debInc == DEB_TGT) begin
                        r_state <= S_PRESSED;
                        r_ce    <= 1'b1;
                        r_dout  <= {r_candRow, r_candCol};
                        r_held  <= 1'b1;
                     end
                  end else begin
                     r_debCnt <= 4'd0;
                     r_state  <= S_SCAN;
                  end
               end
            end

            S_PRESSED: begin
               r_debCnt <= 4'd0;
               r_relCnt <= 4'd0;
               r_state  <= S_WAIT_RELEASE;
            end

            S_WAIT_RELEASE: begin
               if (w_tick) begin
                  if (w_rowIdle) begin
                     if (w_relInc == DEB_TGT) begin
                        r_held   <= 1'b0;
                        r_relCnt <= 4'd0;
                        r_colIdx <= r_colIdx + 2'd1;
                        r_state  <= S_SCAN;
                     end else begin
                        r_relCnt <= w_relInc;
                     end
                  end else begin
                     r_relCnt <= 4'd0;
                  end
               end
            end

            default: begin
               r_state <= S_SCAN;
            end
         endcase
      end
   end

   assign COL  = ~(4'b0001 << r_colIdx);
   assign Dout = r_dout;
   assign Ce   = r_ce;
   assign Held = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3) with a behavioural
// key matrix that pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [3:0]  Dout;
   logic        Ce;
   logic        Held;

   logic [15:0] keys;
   logic [3:0]  scanSeq [4];
   int          testCount = 0;
   int          failCount = 0;
   int          ceCount   = 0;
   int          tbPre     = 0;

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .ROW (ROW),
      .COL (COL),
      .Dout(Dout),
      .Ce  (Ce),
      .Held(Held)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      ROW = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !COL[c]) ROW[r] = 1'b0;
         end
      end
   end

   // Reference prescaler: a tick edge is one where tbPre was SCAN_DIV-1.
   always @(posedge CLK) begin
      if (RST) tbPre <= 0;
      else     tbPre <= (tbPre == SCAN_DIV - 1) ? 0 : tbPre + 1;
   end

   always @(negedge CLK) begin
      if (RST === 1'b0 && Ce === 1'b1) ceCount <= ceCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int key, input logic pressed);
      keys[key] = pressed;
   endtask

   task automatic nextTick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2*SCAN_DIV && !seen; i++) begin
         @(posedge CLK);
         if (tbPre == SCAN_DIV - 1) seen = 1'b1;
      end
      if (!seen) begin
         failCount++;
         $display("[TB] FAIL tickTimeout: observed no tick, required one within %0d cycles", 2*SCAN_DIV);
      end
      #1;
   endtask

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) nextTick();
   endtask

   task automatic pulseReset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      keys = 16'h0000;
      scanSeq[0] = 4'b1101;
      scanSeq[1] = 4'b1011;
      scanSeq[2] = 4'b0111;
      scanSeq[3] = 4'b1110;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      checkOutput("rstCol",  COL,  4'b1110);
      checkOutput("rstDout", Dout, 4'h0);
      checkOutput("rstCe",   Ce,   1'b0);
      checkOutput("rstHeld", Held, 1'b0);

      // Idle scan: one column step per tick, steady in between.
      for (int i = 0; i < 4; i++) begin
         nextTick();
         checkOutput("idleScanCol", COL, scanSeq[i]);
         repeat (3) @(posedge CLK);
         #1;
         checkOutput("idleScanHold", COL, scanSeq[i]);
      end

      // Key 9 (row2/col1), held for 20 ticks.
      applyStimulus(9, 1'b1);
      nextTick();
      checkOutput("k9ColStep", COL, 4'b1101);
      nextTick();
      nextTick();
      checkOutput("k9DebNoCe", Ce, 1'b0);
      nextTick();
      checkOutput("k9Ce",   Ce,   1'b1);
      checkOutput("k9Dout", Dout, 4'h9);
      checkOutput("k9Held", Held, 1'b1);
      @(posedge CLK);
      #1;
      checkOutput("k9CeOneCycle", Ce,   1'b0);
      checkOutput("k9HeldStays",  Held, 1'b1);
      waitTicks(16);
      checkOutput("k9SingleCe",   ceCount, 1);
      checkOutput("k9HeldLong",   Held,    1'b1);
      checkOutput("k9ColFrozen",  COL,     4'b1101);
      applyStimulus(9, 1'b0);
      waitTicks(2);
      checkOutput("k9RelHeld",    Held, 1'b1);
      nextTick();
      checkOutput("k9RelDone",    Held, 1'b0);
      checkOutput("k9RelCol",     COL,  4'b1011);

      // Key F (row3/col3); release wraps the column back to 0.
      applyStimulus(15, 1'b1);
      waitTicks(4);
      checkOutput("kFCe",   Ce,   1'b1);
      checkOutput("kFDout", Dout, 4'hF);
      applyStimulus(15, 1'b0);
      waitTicks(3);
      checkOutput("kFRelCol", COL,     4'b1110);
      checkOutput("kFCount",  ceCount, 2);

      // Key 0 bounces: low 2 ticks, high 1 tick, then low 3 ticks.
      applyStimulus(0, 1'b1);
      waitTicks(2);
      applyStimulus(0, 1'b0);
      nextTick();
      checkOutput("bounceAbortCe",  Ce,   1'b0);
      checkOutput("bounceAbortCol", COL,  4'b1110);
      applyStimulus(0, 1'b1);
      waitTicks(2);
      checkOutput("bounceDebCe",    Ce,   1'b0);
      checkOutput("bounceDoutHeld", Dout, 4'hF);
      nextTick();
      checkOutput("bounceCe",   Ce,   1'b1);
      checkOutput("bounceDout", Dout, 4'h0);
      applyStimulus(0, 1'b0);
      waitTicks(3);
      checkOutput("bounceCount",  ceCount, 3);
      checkOutput("bounceRelCol", COL,     4'b1101);

      // Rows 1 and 2 low together in column 0.
      applyStimulus(4, 1'b1);
      applyStimulus(8, 1'b1);
      waitTicks(6);
      checkOutput("multiRowCe",   Ce,   1'b1);
      checkOutput("multiRowDout", Dout, 4'h4);
      applyStimulus(4, 1'b0);
      applyStimulus(8, 1'b0);
      waitTicks(3);
      checkOutput("multiRowRelCol", COL, 4'b1101);

      // Reset after the second debounce sample of key 5.
      applyStimulus(5, 1'b1);
      waitTicks(2);
      pulseReset();
      checkOutput("midRstCol",  COL,  4'b1110);
      checkOutput("midRstDout", Dout, 4'h0);
      checkOutput("midRstCe",   Ce,   1'b0);
      checkOutput("midRstHeld", Held, 1'b0);
      checkOutput("midRstCount", ceCount, 4);
      waitTicks(3);
      checkOutput("freshDebNoCe", Ce,      1'b0);
      checkOutput("freshDebHeld", Held,    1'b0);
      checkOutput("freshDebCnt",  ceCount, 4);
      nextTick();
      checkOutput("k5Ce",   Ce,   1'b1);
      checkOutput("k5Dout", Dout, 4'h5);
      applyStimulus(5, 1'b0);
      waitTicks(3);
      checkOutput("k5RelCol",  COL,  4'b1011);
      checkOutput("k5RelDout", Dout, 4'h5);

      // Key 6 right after; Dout keeps 5 until the new strobe.
      applyStimulus(6, 1'b1);
      waitTicks(2);
      checkOutput("k6DebDout", Dout, 4'h5);
      nextTick();
      checkOutput("k6Ce",   Ce,   1'b1);
      checkOutput("k6Dout", Dout, 4'h6);
      applyStimulus(6, 1'b0);
      waitTicks(3);
      checkOutput("k6RelHeld", Held,    1'b0);
      checkOutput("k6RelCol",  COL,     4'b0111);
      checkOutput("k6Count",   ceCount, 6);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: CLK cycles per scan tick; legal range 2..2^20.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable scan ticks needed to accept a press or a release; legal range 1..15.
REQ-003 Port CLK, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port RST, input, 1: synchronous, active-high reset.
REQ-005 Port ROW, input, 4: keypad row lines, active-low, pulled up externally, asynchronous to CLK.
REQ-006 Port COL, output, 4: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 Port Dout, output, 4: key code of the last accepted press, code = row_index*4 + col_index; feeds the digit shift register Din.
REQ-008 Port Ce, output, 1: one-cycle strobe marking a new Dout; feeds the digit shift register Ce.
REQ-009 Port Held, output, 1: high from the Ce cycle until the release is accepted.

Function
REQ-010 ROW SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-011 Prescaler: counter 0..SCAN_DIV-1; tick asserted for one cycle when the count equals SCAN_DIV-1, then wraps to 0; it runs in every state.
REQ-012 col_idx (2 bits) SHALL drive COL = ~(1 << col_idx).
REQ-013 FSM states: SCAN, DEBOUNCE, PRESSED, WAIT_RELEASE; all transitions except PRESSED->WAIT_RELEASE occur only on tick.
REQ-014 SCAN, tick, rs == 4'b1111: col_idx increments, wrapping 3->0.
REQ-015 SCAN, tick, any rs bit low: latch cand_row = lowest-index low bit, cand_col = col_idx; deb_cnt = 1; go to DEBOUNCE. If DEBOUNCE == 1, go directly to PRESSED instead.
REQ-016 DEBOUNCE, tick, rs bit cand_row still low: deb_cnt increments; when the new value equals DEBOUNCE, go to PRESSED.
REQ-017 DEBOUNCE, tick, rs bit cand_row high: clear deb_cnt, return to SCAN, col_idx unchanged.
REQ-018 col_idx SHALL NOT change in DEBOUNCE, PRESSED or WAIT_RELEASE.
REQ-019 PRESSED lasts exactly one cycle: Ce = 1; Dout = {cand_row, cand_col} registered in the same cycle Ce is high; Held set; next state WAIT_RELEASE.
REQ-020 Dout SHALL hold its value outside PRESSED.
REQ-021 Ce SHALL be a registered output, high only in the PRESSED cycle.
REQ-022 WAIT_RELEASE, tick, rs == 4'b1111: rel_cnt increments; when it reaches DEBOUNCE, clear Held and rel_cnt, increment col_idx, go to SCAN.
REQ-023 WAIT_RELEASE, tick, any rs bit low: clear rel_cnt.
REQ-024 One physical press SHALL produce exactly one Ce, regardless of hold time.
REQ-025 Multiple rows low in one column: the lowest row index wins.
REQ-026 Multiple keys in different columns: the first column scanned wins; further keys are ignored until the release is accepted.
REQ-027 Latency: Ce rises 1 CLK after the tick that completes DEBOUNCE stable samples.

Reset
REQ-028 RST high at a clock edge SHALL force state SCAN; prescaler, deb_cnt, rel_cnt and col_idx to 0; COL = 4'b1110; Dout = 4'h0; Ce = 0; Held = 0; synchronizer flops to 4'b1111.
REQ-029 Reset SHALL take priority over every transition, including mid-DEBOUNCE and during PRESSED; no Ce is issued in the cycle RST is high.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-030 Press row2/col1 stable for 20 ticks, then release -> exactly one Ce, Dout = 4'h9, Held high until 3 idle ticks after release, then COL advances to 4'b1011.
REQ-031 Press row3/col3 -> Dout = 4'hF; with no key pressed, COL sequence cycles 1110, 1101, 1011, 0111, 1110, advancing every 4 CLK.
REQ-032 Bounce: row low 2 ticks, high 1 tick, then low 3 ticks -> first attempt aborts with no Ce; a single Ce follows the third stable tick.
REQ-033 Rows 1 and 2 both low in col 0 -> Dout = 4'h4 (row 1 wins).
REQ-034 RST pulse during DEBOUNCE tick 2 -> no Ce; all outputs at reset values; a fresh 3-tick debounce is required afterward.
REQ-035 Two presses 5 and 6 in succession, with release -> Ce twice, Dout 4'h5 then 4'h6, and Dout held between the strobes.
